// File: rtl/glip_uart_pkg.sv
// GLIP UART shared types and constants.
// Used by the host-side transmitter and its baud generator.
package glip_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Width needed to hold 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/glip_uart_baud_gen.sv
// Bit-period counter for the GLIP UART.
// Counts 0..DIVISOR-1 while enabled and ticks on the last count.
module glip_uart_baud_gen
  import glip_uart_pkg::*;
#(
  parameter int DIVISOR = 1085
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = clog2(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/glip_uart_host_tx.sv
// Host-end GLIP UART transmitter: 8N1 frames from a valid/ready
// byte stream, gated by the far end's active-low clear-to-send.
module glip_uart_host_tx
  import glip_uart_pkg::*;
#(
  parameter int FREQ      = 125000000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       uart_tx,
  input  logic       uart_cts_n,
  output logic       busy
);

  localparam int DIVISOR = FREQ / BAUD;
  localparam int BW = clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(UART_DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if (DIVISOR < 2) begin : g_div_chk
    $error("glip_uart_host_tx: FREQ/BAUD must be >= 2");
  end

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("glip_uart_host_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t   state;
  logic [7:0]    shreg;
  logic [BW-1:0] bit_cnt;
  logic          stop_cnt;
  logic          cts_q1;
  logic          cts_s;
  logic          tick;
  logic          baud_clr;
  logic          baud_en;
  logic          xfer;

  // cts_n is asynchronous; resets to "not clear".
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_q1 <= 1'b1;
      cts_s  <= 1'b1;
    end else begin
      cts_q1 <= uart_cts_n;
      cts_s  <= cts_q1;
    end
  end

  assign in_ready = (state == IDLE) && !cts_s;
  assign xfer     = in_valid && in_ready;
  assign baud_clr = (state == IDLE);
  assign baud_en  = (state != IDLE);

  glip_uart_baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .en   (baud_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      uart_tx  <= UART_IDLE_LEVEL;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            state    <= START;
            shreg    <= in_data;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            uart_tx  <= ~UART_IDLE_LEVEL;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= STOP;
              uart_tx <= UART_IDLE_LEVEL;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= UART_IDLE_LEVEL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glip_uart_host_tx.sv
// Directed bench for glip_uart_host_tx at four clocks per bit,
// with a line-level 8N1 receiver model decoding uart_tx.
module tb_glip_uart_host_tx;

  localparam int DIV = 4;
  localparam int N_SOAK = 150;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       uart_tx;
  logic       uart_cts_n = 1'b0;
  logic       busy;

  int n_chk = 0;
  int n_pass = 0;
  int ferr = 0;
  int to_err = 0;
  logic rx_en = 1'b0;
  logic soak_on = 1'b0;
  logic [7:0] rx_b;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  glip_uart_host_tx #(
    .FREQ      (4),
    .BAUD      (1),
    .STOP_BITS (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .uart_tx    (uart_tx),
    .uart_cts_n (uart_cts_n),
    .busy       (busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Receiver: sample mid-bit on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && uart_tx === 1'b0) begin
        @(negedge clk);
        if (uart_tx !== 1'b0) ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          rx_b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        if (uart_tx !== 1'b1) ferr++;
        else rxq.push_back(rx_b);
      end
    end
  end

  initial begin
    #800us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic rx_expect(input string tag, input logic [7:0] exp);
    logic [63:0] got;
    got = 64'hDEAD;
    if (rxq.size() > 0) got = {56'h0, rxq.pop_front()};
    check(tag, got, {56'h0, exp});
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    wait_ready(ok);
    if (!ok) begin
      to_err++;
    end else begin
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int bad;
    int n;
    bit ok;
    logic prev;
    logic [7:0] b;
    logic [39:0] obs;
    logic [39:0] exp;

    // Reset and synchroniser latency.
    rst = 1'b1;
    uart_cts_n = 1'b0;
    @(posedge clk);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
        bad++;
    end
    check("reset_idle", bad, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_sync1", in_ready, 0);
    @(negedge clk);
    check("rdy_sync2", in_ready, 1);
    check("idle_tx", uart_tx, 1);
    rx_en = 1'b1;

    // Single byte 0xA5, cycle-accurate waveform.
    b = 8'hA5;
    for (int k = 0; k < 40; k++) begin
      if (k < 4) exp[k] = 1'b0;
      else if (k < 36) exp[k] = b[(k - 4) / 4];
      else exp[k] = 1'b1;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      obs[k] = uart_tx;
      if (k == 0) check("a5_busy", busy, 1);
      @(posedge clk);
      #1;
    end
    check("a5_wave", obs, exp);
    check("a5_done_busy", busy, 0);
    check("a5_done_rdy", in_ready, 1);
    repeat (3) @(negedge clk);
    rx_expect("rx_a5", 8'hA5);

    // Back-to-back 0x00 then 0xFF with in_valid held.
    wait_ready(ok);
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'hFF;
    prev = uart_tx;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 n++;
      if (prev === 1'b1 && uart_tx === 1'b0) break;
      prev = uart_tx;
    end
    in_valid = 1'b0;
    check("b2b_gap", n, 41);
    wait_idle();
    rx_expect("rx_00", 8'h00);
    rx_expect("rx_ff", 8'hFF);

    // Flow control: CTS drops mid-frame of 0x3C.
    wait_ready(ok);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'h5A;
    repeat (12) @(negedge clk);
    uart_cts_n = 1'b1;
    wait_idle();
    rx_expect("rx_3c", 8'h3C);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("cts_hold", bad, 0);
    uart_cts_n = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 n++;
      if (uart_tx === 1'b0) break;
    end
    in_valid = 1'b0;
    check("cts_resume", n, 3);
    wait_idle();
    rx_expect("rx_5a", 8'h5A);

    // Reset during data bit 4 of 0x00.
    rx_en = 1'b0;
    wait_ready(ok);
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_tx", uart_tx, 1);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    check("rst_no_low", bad, 0);
    rx_en = 1'b1;
    send(8'h81);
    wait_idle();
    rx_expect("rx_81", 8'h81);

    // Soak: random gaps and CTS toggling.
    soak_on = 1'b1;
    fork
      begin
        while (soak_on) begin
          if (uart_cts_n) repeat ($urandom_range(5, 40)) @(negedge clk);
          else repeat ($urandom_range(5, 120)) @(negedge clk);
          uart_cts_n = soak_on ? ~uart_cts_n : 1'b0;
        end
        uart_cts_n = 1'b0;
      end
      begin
        for (int i = 0; i < N_SOAK; i++) begin
          repeat ($urandom_range(0, 6)) @(negedge clk);
          b = 8'($urandom);
          send(b);
          expq.push_back(b);
        end
        soak_on = 1'b0;
      end
    join
    wait_idle();
    repeat (5) @(negedge clk);
    check("soak_count", rxq.size(), N_SOAK);
    bad = 0;
    for (int i = 0; i < N_SOAK; i++) begin
      if (i >= rxq.size() || rxq[i] !== expq[i]) bad++;
    end
    check("soak_bytes", bad, 0);
    check("framing", ferr, 0);
    check("timeouts", to_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
